// File: rtl/crypto1_pkg.sv
// Shared constants, arbiter state encoding and the backward LFSR step for the Crypto1 key arbiter.
// ST_REWIND exists only when CRYPTO1_REWIND_EN is defined.
package crypto1_pkg;

    localparam int C1_KEY_BITS = 48;
    localparam int C1_REWIND   = 45;
    // Bit 47 must be a tap, otherwise the forward step would not be invertible.
    localparam logic [C1_KEY_BITS-1:0] C1_TAPS = 48'h846B50D41170;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_PRESENT = 3'd3,
        ST_RELEASE = 3'd4,
        ST_FINISH  = 3'd5
`ifdef CRYPTO1_REWIND_EN
        , ST_REWIND = 3'd6
`endif
    } arb_state_t;

    // Undoes s' = {s[46:0], ^(s & C1_TAPS)}.
    function automatic logic [C1_KEY_BITS-1:0] c1_rewind_step(input logic [C1_KEY_BITS-1:0] s);
        return {s[0] ^ (^(s[C1_KEY_BITS-1:1] & C1_TAPS[C1_KEY_BITS-2:0])), s[C1_KEY_BITS-1:1]};
    endfunction

endpackage

// File: rtl/crypto1_rr_pick.sv
// Round-robin first-set-bit finder: lowest requester at or after ptr, wrapping modulo N.
// Purely combinational; ptr is assumed to be below N.
module crypto1_rr_pick #(
    parameter int N  = 256,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            idx = IW'((sum >= (IW+1)'(N)) ? sum - (IW+1)'(N) : sum);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/crypto1_key_arbiter.sv
// Crypto1 search-core sequencer: round-robin key readout, verifier handshake, core release, DONE.
// Define CRYPTO1_REWIND_EN to rewind each candidate REWIND LFSR steps before presenting it.
//
// state      | meaning
// IDLE       | waiting for START after reset
// SCAN       | pick next valid core, or finish when all cores are exhausted
// SHIFT      | serial readout, two cycles per bit, KEY_CLK high in phase 1
// REWIND     | step the key backwards REWIND times (optional)
// PRESENT    | KEY_VALID high until the verifier takes the key
// RELEASE    | one-cycle CORE_CLR pulse to the source core, advance pointer
// FINISH     | DONE held until the next START
module crypto1_key_arbiter
    import crypto1_pkg::*;
#(
    parameter int NCORES   = 256,
    parameter int KEY_BITS = C1_KEY_BITS,
    parameter int REWIND   = C1_REWIND,
    localparam int IW      = (NCORES > 1) ? $clog2(NCORES) : 1
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                START,
    input  logic [NCORES-1:0]   CORE_VALID,
    input  logic [NCORES-1:0]   CORE_DATA,
    input  logic [NCORES-1:0]   CORE_DONE,
    output logic                KEY_CLK,
    output logic                CORE_RUN,
    output logic [NCORES-1:0]   CORE_CLR,
    output logic [KEY_BITS-1:0] KEY,
    output logic [IW-1:0]       KEY_SRC,
    output logic                KEY_VALID,
    input  logic                KEY_READY,
    output logic [15:0]         CAND_CNT,
    output logic                DONE
);

    localparam int BW = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [BW-1:0] bit_cnt;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

`ifdef CRYPTO1_REWIND_EN
    localparam int RW = $clog2(REWIND + 1);
    logic [RW-1:0] rew_cnt;
`endif

    crypto1_rr_pick #(.N(NCORES), .IW(IW)) u_pick (
        .req   (CORE_VALID),
        .ptr   (ptr),
        .grant (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            bit_cnt   <= '0;
            KEY_CLK   <= 1'b0;
            CORE_RUN  <= 1'b0;
            CORE_CLR  <= '0;
            KEY       <= '0;
            KEY_SRC   <= '0;
            KEY_VALID <= 1'b0;
            CAND_CNT  <= '0;
            DONE      <= 1'b0;
`ifdef CRYPTO1_REWIND_EN
            rew_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_FINISH: begin
                    if (START) begin
                        CORE_RUN <= 1'b1;
                        DONE     <= 1'b0;
                        CAND_CNT <= '0;
                        ptr      <= '0;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // A pending candidate wins over exhaustion so no key is dropped.
                    if (pick_any) begin
                        KEY_SRC <= pick_idx;
                        bit_cnt <= '0;
                        KEY     <= '0;
                        state   <= ST_SHIFT;
                    end else if (&CORE_DONE) begin
                        CORE_RUN <= 1'b0;
                        DONE     <= 1'b1;
                        state    <= ST_FINISH;
                    end
                end
                ST_SHIFT: begin
                    if (!KEY_CLK) begin
                        KEY     <= {KEY[KEY_BITS-2:0], CORE_DATA[KEY_SRC]};
                        KEY_CLK <= 1'b1;
                    end else begin
                        KEY_CLK <= 1'b0;
                        bit_cnt <= bit_cnt + BW'(1);
                        if (bit_cnt == BW'(KEY_BITS - 1)) begin
`ifdef CRYPTO1_REWIND_EN
                            rew_cnt <= RW'(REWIND);
                            state   <= ST_REWIND;
`else
                            KEY_VALID <= 1'b1;
                            state     <= ST_PRESENT;
`endif
                        end
                    end
                end
`ifdef CRYPTO1_REWIND_EN
                ST_REWIND: begin
                    KEY     <= c1_rewind_step(KEY);
                    rew_cnt <= rew_cnt - RW'(1);
                    if (rew_cnt == RW'(1)) begin
                        KEY_VALID <= 1'b1;
                        state     <= ST_PRESENT;
                    end
                end
`endif
                ST_PRESENT: begin
                    if (KEY_VALID && KEY_READY) begin
                        KEY_VALID <= 1'b0;
                        if (CAND_CNT != 16'hFFFF) CAND_CNT <= CAND_CNT + 16'd1;
                        CORE_CLR  <= {{(NCORES-1){1'b0}}, 1'b1} << KEY_SRC;
                        state     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    CORE_CLR <= '0;
                    ptr      <= (KEY_SRC == IW'(NCORES - 1)) ? '0 : KEY_SRC + IW'(1);
                    state    <= ST_SCAN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
